// File: rtl/matrix_mult_param_if.sv
// Bus bundle for matrix_mult_param: start/mode/operands in, result and status out.
// The master drives the request side, the slave (the multiplier) drives the result side.
interface matrix_mult_param_if #(
    parameter int N  = 3,
    parameter int DW = 8,
    parameter int OW = 16
);
    logic                  start;
    logic                  signed_mode;
    logic [N*N*DW-1:0]     a_flat;
    logic [N*N*DW-1:0]     b_flat;
    logic [N*N*OW-1:0]     c_flat;
    logic                  busy;
    logic                  done;
    logic                  sat;

    modport master (
        output start, signed_mode, a_flat, b_flat,
        input  c_flat, busy, done, sat
    );

    modport slave (
        input  start, signed_mode, a_flat, b_flat,
        output c_flat, busy, done, sat
    );
endinterface

// File: rtl/matrix_mult_param.sv
// Sequential NxN matrix multiplier: one shared multiplier, one MAC per cycle, atomic result update.
// Optional output clamping is enabled by defining MATMUL_SAT_EN; otherwise results wrap to OW bits.
module matrix_mult_param #(
    parameter int N  = 3,
    parameter int DW = 8,
    parameter int OW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    matrix_mult_param_if.slave   bus
);
    localparam int NE  = N * N;
    localparam int IW  = $clog2(N);
    localparam int EW  = $clog2(NE);
    localparam int ACW = 2 * DW + 4;
    localparam int PW  = 2 * DW + 2;
`ifdef MATMUL_SAT_EN
    localparam int SHW = ACW;
    localparam int XW  = ACW + 1;
    localparam logic signed [XW-1:0] SMAX = (XW'(1) << (OW - 1)) - XW'(1);
    localparam logic signed [XW-1:0] SMIN = ~SMAX;
    localparam logic signed [XW-1:0] UMAX = (XW'(1) << OW) - XW'(1);
`else
    localparam int SHW = OW;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [DW-1:0]           a_mem [NE];
    logic [DW-1:0]           b_mem [NE];
    logic                    sm_q;
    logic [IW-1:0]           i_q, j_q, k_q;
    logic signed [ACW-1:0]   acc;
    logic [SHW-1:0]          shadow [NE];
    logic [NE*OW-1:0]        c_q;

    logic                    last_k, last_j, last_elem;
    logic [EW-1:0]           a_idx, b_idx, c_idx;
    logic [DW-1:0]           a_op, b_op;
    logic signed [DW:0]      a_ext, b_ext;
    logic signed [PW-1:0]    product;
    logic signed [ACW-1:0]   acc_sum;
    logic [SHW-1:0]          res [NE];
    logic [NE*OW-1:0]        c_next;
    logic                    sat_next;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_MAC:   if (last_elem) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: if (bus.start) state_next = S_MAC;  // IDLE and the unused encoding
        endcase
    end

    assign bus.busy = (state == S_MAC) || (state == S_DONE);
    assign bus.done = (state == S_DONE);

    // ------------------------------------------------------------------
    // Shared multiply-accumulate
    // ------------------------------------------------------------------
    assign last_k    = (k_q == IW'(N - 1));
    assign last_j    = (j_q == IW'(N - 1));
    assign last_elem = last_k && last_j && (i_q == IW'(N - 1));

    assign a_idx = EW'(int'(i_q) * N + int'(k_q));
    assign b_idx = EW'(int'(k_q) * N + int'(j_q));
    assign c_idx = EW'(int'(i_q) * N + int'(j_q));

    assign a_op  = a_mem[a_idx];
    assign b_op  = b_mem[b_idx];
    assign a_ext = {sm_q & a_op[DW-1], a_op};
    assign b_ext = {sm_q & b_op[DW-1], b_op};

    assign product = a_ext * b_ext;
    assign acc_sum = acc + {{(ACW - PW){product[PW-1]}}, product};

    // Final element bypasses the shadow so the whole matrix lands in c_flat on one edge.
    always_comb begin
        for (int e = 0; e < NE; e++) begin
            res[e] = shadow[e];
        end
        res[NE-1] = acc_sum[SHW-1:0];
    end

`ifdef MATMUL_SAT_EN
    logic signed [XW-1:0] val;

    always_comb begin
        sat_next = 1'b0;
        c_next   = '0;
        val      = '0;
        for (int e = 0; e < NE; e++) begin
            val = {res[e][SHW-1], res[e]};
            if (sm_q) begin
                if (val > SMAX) begin
                    c_next[e*OW +: OW] = SMAX[OW-1:0];
                    sat_next           = 1'b1;
                end else if (val < SMIN) begin
                    c_next[e*OW +: OW] = SMIN[OW-1:0];
                    sat_next           = 1'b1;
                end else begin
                    c_next[e*OW +: OW] = val[OW-1:0];
                end
            end else begin
                if (val > UMAX) begin
                    c_next[e*OW +: OW] = UMAX[OW-1:0];
                    sat_next           = 1'b1;
                end else if (val[XW-1]) begin
                    c_next[e*OW +: OW] = '0;
                    sat_next           = 1'b1;
                end else begin
                    c_next[e*OW +: OW] = val[OW-1:0];
                end
            end
        end
    end

    logic sat_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                            sat_q <= 1'b0;
        else if (state == S_MAC && last_elem) sat_q <= sat_next;
    end

    assign bus.sat = sat_q;
`else
    always_comb begin
        sat_next = 1'b0;
        c_next   = '0;
        for (int e = 0; e < NE; e++) begin
            c_next[e*OW +: OW] = res[e];
        end
    end

    assign bus.sat = sat_next;
`endif

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: operand and shadow arrays are reset because a reset must leave no stale result behind.
            for (int e = 0; e < NE; e++) begin
                a_mem[e]  <= '0;
                b_mem[e]  <= '0;
                shadow[e] <= '0;
            end
            sm_q <= 1'b0;
            i_q  <= '0;
            j_q  <= '0;
            k_q  <= '0;
            acc  <= '0;
            c_q  <= '0;
        end else begin
            case (state)
                S_MAC: begin
                    if (last_k) begin
                        shadow[c_idx] <= acc_sum[SHW-1:0];
                        acc           <= '0;
                        k_q           <= '0;
                        if (last_j) begin
                            j_q <= '0;
                            i_q <= last_elem ? '0 : i_q + IW'(1);
                        end else begin
                            j_q <= j_q + IW'(1);
                        end
                    end else begin
                        acc <= acc_sum;
                        k_q <= k_q + IW'(1);
                    end
                    if (last_elem) c_q <= c_next;
                end
                S_DONE: ;
                default: begin
                    if (bus.start) begin
                        for (int e = 0; e < NE; e++) begin
                            a_mem[e] <= bus.a_flat[e*DW +: DW];
                            b_mem[e] <= bus.b_flat[e*DW +: DW];
                        end
                        sm_q <= bus.signed_mode;
                        i_q  <= '0;
                        j_q  <= '0;
                        k_q  <= '0;
                        acc  <= '0;
                    end
                end
            endcase
        end
    end

    assign bus.c_flat = c_q;
endmodule

// File: tb/tb_matrix_mult_param.sv
// Self-checking bench for matrix_mult_param (N=3, DW=8, OW=16): directed table, corner sequences, random vs model.
// Expectations follow MATMUL_SAT_EN when it is defined for the build.
module tb_matrix_mult_param;
    localparam int N  = 3;
    localparam int DW = 8;
    localparam int OW = 16;
    localparam int AW = N * N * DW;
    localparam int CW = N * N * OW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    matrix_mult_param_if #(.N(N), .DW(DW), .OW(OW)) bus ();

    matrix_mult_param #(.N(N), .DW(DW), .OW(OW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        string         name;
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic          sm;
        logic [CW-1:0] c;
        logic          s;
    } vec_t;

    vec_t vecs [5];

    function automatic logic [AW-1:0] fill_op(input logic [DW-1:0] v);
        logic [AW-1:0] r;
        for (int e = 0; e < N * N; e++) r[e*DW +: DW] = v;
        return r;
    endfunction

    function automatic logic [CW-1:0] fill_res(input logic [OW-1:0] v);
        logic [CW-1:0] r;
        for (int e = 0; e < N * N; e++) r[e*OW +: OW] = v;
        return r;
    endfunction

    function automatic logic [AW-1:0] ident_op();
        logic [AW-1:0] r = '0;
        for (int i = 0; i < N; i++) r[(i*N+i)*DW +: DW] = DW'(1);
        return r;
    endfunction

    function automatic logic [AW-1:0] seq_op();
        logic [AW-1:0] r;
        for (int e = 0; e < N * N; e++) r[e*DW +: DW] = DW'(e + 1);
        return r;
    endfunction

    function automatic logic [CW-1:0] seq_res();
        logic [CW-1:0] r;
        for (int e = 0; e < N * N; e++) r[e*OW +: OW] = OW'(e + 1);
        return r;
    endfunction

    // Reference: plain integer matrix product, then wrap or clamp to OW bits.
    task automatic model(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic sm,
                         output logic [CW-1:0] c, output logic s);
        s = 1'b0;
        c = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                int sum;
                sum = 0;
                for (int k = 0; k < N; k++) begin
                    logic [DW-1:0] ae, be;
                    int av, bv;
                    ae = a[(i*N+k)*DW +: DW];
                    be = b[(k*N+j)*DW +: DW];
                    if (sm) begin
                        av = int'($signed(ae));
                        bv = int'($signed(be));
                    end else begin
                        av = int'(ae);
                        bv = int'(be);
                    end
                    sum += av * bv;
                end
`ifdef MATMUL_SAT_EN
                begin
                    int lo, hi;
                    lo = sm ? -(1 << (OW - 1)) : 0;
                    hi = sm ? (1 << (OW - 1)) - 1 : (1 << OW) - 1;
                    if (sum > hi) begin
                        sum = hi;
                        s = 1'b1;
                    end else if (sum < lo) begin
                        sum = lo;
                        s = 1'b1;
                    end
                end
`endif
                c[(i*N+j)*OW +: OW] = sum[OW-1:0];
            end
        end
    endtask

    // Issue one start and follow the run until busy drops (bounded).
    task automatic run_op(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic sm,
                          output int done_at, output int done_cnt, output int busy_cnt);
        int cyc;
        bus.a_flat      = a;
        bus.b_flat      = b;
        bus.signed_mode = sm;
        bus.start       = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        busy_cnt  = bus.busy ? 1 : 0;
        done_at   = -1;
        done_cnt  = 0;
        cyc       = 0;
        while (bus.busy && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (done_at < 0) done_at = cyc;
            end
        end
    endtask

    initial begin
        int done_at, done_cnt, busy_cnt, cyc;
        logic [CW-1:0] exp_c;
        logic          exp_s;

        vecs[0] = '{"ident_x_seq", ident_op(), seq_op(), 1'b0, seq_res(), 1'b0};
        vecs[1] = '{"ff_x_02_signed", fill_op(8'hFF), fill_op(8'h02), 1'b1, fill_res(16'hFFFA), 1'b0};
        vecs[2] = '{"ff_x_02_unsigned", fill_op(8'hFF), fill_op(8'h02), 1'b0, fill_res(16'h05FA), 1'b0};
`ifdef MATMUL_SAT_EN
        vecs[3] = '{"ff_x_ff_unsigned", fill_op(8'hFF), fill_op(8'hFF), 1'b0, fill_res(16'hFFFF), 1'b1};
        vecs[4] = '{"80_x_80_signed", fill_op(8'h80), fill_op(8'h80), 1'b1, fill_res(16'h7FFF), 1'b1};
`else
        vecs[3] = '{"ff_x_ff_unsigned", fill_op(8'hFF), fill_op(8'hFF), 1'b0, fill_res(16'hFA03), 1'b0};
        vecs[4] = '{"80_x_80_signed", fill_op(8'h80), fill_op(8'h80), 1'b1, fill_res(16'hC000), 1'b0};
`endif

        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.signed_mode = 1'b0;
        bus.a_flat      = '0;
        bus.b_flat      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", CW'(bus.busy), '0);
        check("reset_done", CW'(bus.done), '0);
        check("reset_sat", CW'(bus.sat), '0);
        check("reset_c", bus.c_flat, '0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed table
        foreach (vecs[v]) begin
            run_op(vecs[v].a, vecs[v].b, vecs[v].sm, done_at, done_cnt, busy_cnt);
            check($sformatf("%s_done_at", vecs[v].name), CW'(done_at), CW'(27));
            check($sformatf("%s_done_cnt", vecs[v].name), CW'(done_cnt), CW'(1));
            check($sformatf("%s_busy_cycles", vecs[v].name), CW'(busy_cnt), CW'(28));
            check($sformatf("%s_c", vecs[v].name), bus.c_flat, vecs[v].c);
            check($sformatf("%s_sat", vecs[v].name), CW'(bus.sat), CW'(vecs[v].s));
        end

        // Result holds while idle inputs wander
        bus.a_flat      = fill_op(8'h33);
        bus.b_flat      = fill_op(8'h77);
        bus.signed_mode = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("hold_c", bus.c_flat, vecs[4].c);
        check("hold_sat", CW'(bus.sat), CW'(vecs[4].s));
        check("hold_busy", CW'(bus.busy), '0);

        // Operand change and extra start pulses during a run are ignored
        bus.a_flat      = ident_op();
        bus.b_flat      = seq_op();
        bus.signed_mode = 1'b0;
        bus.start       = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        done_at   = -1;
        done_cnt  = 0;
        for (cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                done_cnt++;
                if (done_at < 0) done_at = cyc;
            end
            if (cyc == 3) begin
                bus.a_flat      = fill_op(8'h55);
                bus.b_flat      = fill_op(8'hAA);
                bus.signed_mode = 1'b1;
            end
            bus.start = (cyc == 5 || cyc == 12);
        end
        check("ignore_done_at", CW'(done_at), CW'(27));
        check("ignore_done_cnt", CW'(done_cnt), CW'(1));
        check("ignore_c", bus.c_flat, seq_res());
        check("ignore_idle_after", CW'(bus.busy), '0);

        // Reset in the middle of a run
        bus.a_flat      = fill_op(8'hFF);
        bus.b_flat      = fill_op(8'hFF);
        bus.signed_mode = 1'b0;
        bus.start       = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_busy", CW'(bus.busy), '0);
        check("midrst_done", CW'(bus.done), '0);
        check("midrst_sat", CW'(bus.sat), '0);
        check("midrst_c", bus.c_flat, '0);
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        done_cnt = 0;
        for (cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk);
            #1;
            if (bus.done) done_cnt++;
        end
        check("midrst_no_done", CW'(done_cnt), '0);
        run_op(ident_op(), seq_op(), 1'b0, done_at, done_cnt, busy_cnt);
        check("postrst_done_at", CW'(done_at), CW'(27));
        check("postrst_c", bus.c_flat, seq_res());

        // Random operands against the reference model
        for (int t = 0; t < 16; t++) begin
            logic [AW-1:0] ra, rb;
            logic          rsm;
            ra  = AW'({$urandom(), $urandom(), $urandom()});
            rb  = AW'({$urandom(), $urandom(), $urandom()});
            rsm = 1'($urandom_range(0, 1));
            if (t < 2) begin
                ra = fill_op(t == 0 ? 8'h7F : 8'h81);
                rb = fill_op(t == 0 ? 8'h7F : 8'h80);
            end
            model(ra, rb, rsm, exp_c, exp_s);
            run_op(ra, rb, rsm, done_at, done_cnt, busy_cnt);
            check($sformatf("rand%0d_done_at", t), CW'(done_at), CW'(27));
            check($sformatf("rand%0d_c", t), bus.c_flat, exp_c);
            check($sformatf("rand%0d_sat", t), CW'(bus.sat), CW'(exp_s));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
